// File: rtl/cycle_input_ctrl.sv
// cycle_input_ctrl: debounces the four turn buttons and queues per-player turns applied one per game step.
module cycle_input_ctrl #(
  parameter int DEB_LEN = 3,
  parameter int Q_DEPTH = 2,
  parameter logic [3:0] INIT_DIR_1 = 4'b0001,
  parameter logic [3:0] INIT_DIR_2 = 4'b0100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_en,
  input  logic       step_en,
  input  logic       game_active,
  input  logic       btn_l1,
  input  logic       btn_r1,
  input  logic       btn_l2,
  input  logic       btn_r2,
  output logic [3:0] dir_1,
  output logic [3:0] dir_2,
  output logic [2:0] qcnt_1,
  output logic [2:0] qcnt_2,
  output logic       ovf_1,
  output logic       ovf_2
);
  logic [3:0] w_btn;
  logic [3:0] w_press;
  logic [3:0] w_dir [2];
  logic [2:0] w_cnt [2];
  logic [1:0] w_ovf;
  assign w_btn = {btn_r2, btn_l2, btn_r1, btn_l1};
  genvar b, p;
  for (b = 0; b < 4; b++) begin : g_deb
    logic [DEB_LEN-1:0] r_hist;
    logic               r_lvl;
    logic               r_press;
    logic [DEB_LEN-1:0] w_next;
    assign w_next = {r_hist[DEB_LEN-2:0], w_btn[b]};
    assign w_press[b] = r_press;
    // press is registered so it fires the cycle after the qualifying sample
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_hist  <= '0;
        r_lvl   <= 1'b0;
        r_press <= 1'b0;
      end else begin
        r_press <= sample_en & (&w_next) & ~r_lvl;
        if (sample_en) begin
          r_hist <= w_next;
          r_lvl  <= (&w_next) | (r_lvl & (|w_next));
        end
      end
    end
  end
  for (p = 0; p < 2; p++) begin : g_ply
    localparam logic [3:0] INIT = (p == 0) ? INIT_DIR_1 : INIT_DIR_2;
    logic [3:0]         r_dir;
    logic [2:0]         r_cnt;
    logic               r_ovf;
    logic [Q_DEPTH-1:0] r_q;
    logic [Q_DEPTH-1:0] w_qn;
    logic [2:0]         w_cp;
    logic               w_ev, w_cmd, w_full, w_pop, w_push;
    assign w_ev   = w_press[2*p] | w_press[2*p+1];
    assign w_cmd  = ~w_press[2*p];
    assign w_full = r_cnt == 3'(Q_DEPTH);
    assign w_pop  = game_active & step_en & (r_cnt != 3'd0);
    assign w_push = game_active & w_ev & (~w_full | w_pop);
    assign w_cp   = r_cnt - 3'(w_pop);
    // entry 0 is the head; new command lands just past the surviving entries
    always_comb begin
      w_qn = w_pop ? (r_q >> 1) : r_q;
      for (int i = 0; i < Q_DEPTH; i++)
        if (w_push && w_cp == 3'(i)) w_qn[i] = w_cmd;
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_dir <= INIT;
        r_cnt <= 3'd0;
        r_ovf <= 1'b0;
        r_q   <= '0;
      end else if (!game_active) begin
        r_dir <= INIT;
        r_cnt <= 3'd0;
      end else begin
        r_cnt <= w_cp + 3'(w_push);
        r_q   <= w_qn;
        if (w_ev && w_full && !w_pop) r_ovf <= 1'b1;
        if (w_pop) r_dir <= r_q[0] ? {r_dir[0], r_dir[3:1]} : {r_dir[2:0], r_dir[3]};
      end
    end
    assign w_dir[p] = r_dir;
    assign w_cnt[p] = r_cnt;
    assign w_ovf[p] = r_ovf;
  end
  assign dir_1  = w_dir[0];
  assign dir_2  = w_dir[1];
  assign qcnt_1 = w_cnt[0];
  assign qcnt_2 = w_cnt[1];
  assign ovf_1  = w_ovf[0];
  assign ovf_2  = w_ovf[1];
endmodule

// File: tb/tb_cycle_input_ctrl.sv
// tb_cycle_input_ctrl: randomized and directed stimulus, queue-based reference model and scoreboard monitor.
module tb_cycle_input_ctrl;
  localparam int DEB_LEN = 3;
  localparam int Q_DEPTH = 2;
  logic clk = 1'b0, rst = 1'b1, sample_en = 1'b0, step_en = 1'b0, game_active = 1'b0;
  logic btn_l1 = 1'b0, btn_r1 = 1'b0, btn_l2 = 1'b0, btn_r2 = 1'b0;
  logic [3:0] dir_1, dir_2;
  logic [2:0] qcnt_1, qcnt_2;
  logic ovf_1, ovf_2;
  int checks = 0, failures = 0;

  typedef struct {logic [3:0] d1, d2; logic [2:0] q1, q2; logic o1, o2;} exp_t;
  exp_t exp_q[$];

  // model state: heading as an index into {D,R,U,L} bit positions
  int  mk [2];
  bit  mq [2][$];
  bit  movf [2];
  bit  hs [4][$];
  bit  mlvl [4];
  bit  mpress [4];

  cycle_input_ctrl #(.DEB_LEN(DEB_LEN), .Q_DEPTH(Q_DEPTH), .INIT_DIR_1(4'b0001), .INIT_DIR_2(4'b0100)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .step_en(step_en), .game_active(game_active),
    .btn_l1(btn_l1), .btn_r1(btn_r1), .btn_l2(btn_l2), .btn_r2(btn_r2),
    .dir_1(dir_1), .dir_2(dir_2), .qcnt_1(qcnt_1), .qcnt_2(qcnt_2), .ovf_1(ovf_1), .ovf_2(ovf_2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mk[0] = 0;
    mk[1] = 2;
    for (int p = 0; p < 2; p++) begin
      mq[p].delete();
      movf[p] = 0;
    end
    for (int j = 0; j < 4; j++) begin
      hs[j].delete();
      for (int n = 0; n < DEB_LEN; n++) hs[j].push_back(0);
      mlvl[j] = 0;
      mpress[j] = 0;
    end
  endtask

  task automatic model_step();
    bit b [4];
    exp_t e;
    b = '{btn_l1, btn_r1, btn_l2, btn_r2};
    if (rst) model_reset();
    else begin
      for (int p = 0; p < 2; p++) begin
        if (!game_active) begin
          mq[p].delete();
          mk[p] = (p == 0) ? 0 : 2;
        end else begin
          if (step_en && mq[p].size() > 0) mk[p] = mq[p].pop_front() ? (mk[p] + 3) % 4 : (mk[p] + 1) % 4;
          if (mpress[2*p] || mpress[2*p+1]) begin
            if (mq[p].size() < Q_DEPTH) mq[p].push_back(mpress[2*p] ? 1'b0 : 1'b1);
            else movf[p] = 1;
          end
        end
      end
      for (int j = 0; j < 4; j++) begin
        mpress[j] = 0;
        if (sample_en) begin
          int ones;
          bit nl;
          hs[j].push_back(b[j]);
          void'(hs[j].pop_front());
          ones = 0;
          foreach (hs[j][n]) ones += hs[j][n];
          nl = (ones == DEB_LEN) ? 1'b1 : (ones == 0) ? 1'b0 : mlvl[j];
          mpress[j] = nl && !mlvl[j];
          mlvl[j] = nl;
        end
      end
    end
    e.d1 = 4'(1 << mk[0]);
    e.d2 = 4'(1 << mk[1]);
    e.q1 = 3'(mq[0].size());
    e.q2 = 3'(mq[1].size());
    e.o1 = movf[0];
    e.o2 = movf[1];
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("sb_dir_1", dir_1, e.d1);
      chk("sb_dir_2", dir_2, e.d2);
      chk("sb_qcnt_1", {1'b0, qcnt_1}, {1'b0, e.q1});
      chk("sb_qcnt_2", {1'b0, qcnt_2}, {1'b0, e.q2});
      chk("sb_ovf_1", {3'b0, ovf_1}, {3'b0, e.o1});
      chk("sb_ovf_2", {3'b0, ovf_2}, {3'b0, e.o2});
    end
  end

  task automatic tick(input logic s, input logic st);
    sample_en = s;
    step_en = st;
    @(posedge clk);
    model_step();
    #1;
    sample_en = 1'b0;
    step_en = 1'b0;
  endtask

  task automatic press_l1();
    btn_l1 = 1'b1;
    repeat (3) tick(1, 0);
    btn_l1 = 1'b0;
    repeat (3) tick(1, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) tick(0, 0);
    rst = 1'b0;
    repeat (10) tick(1, 0);
    chk("rst_dir_1", dir_1, 4'b0001);
    chk("rst_dir_2", dir_2, 4'b0100);
    chk("rst_qcnt_1", {1'b0, qcnt_1}, 4'd0);
    chk("rst_ovf", {2'b0, ovf_1, ovf_2}, 4'd0);
    game_active = 1'b1;
    btn_l1 = 1'b1;
    repeat (3) tick(1, 0);
    tick(0, 0);
    chk("press_qcnt_1", {1'b0, qcnt_1}, 4'd1);
    btn_l1 = 1'b0;
    tick(0, 1);
    chk("left_dir_1", dir_1, 4'b0010);
    chk("pop_qcnt_1", {1'b0, qcnt_1}, 4'd0);
    repeat (3) tick(1, 0);
    foreach (exp_q[i]) ;
    for (int i = 0; i < 4; i++) begin
      btn_r2 = (i % 2 == 0);
      tick(1, 0);
    end
    repeat (2) tick(0, 0);
    chk("bounce_qcnt_2", {1'b0, qcnt_2}, 4'd0);
    btn_r2 = 1'b1;
    repeat (3) tick(1, 0);
    repeat (2) tick(0, 0);
    chk("clean_qcnt_2", {1'b0, qcnt_2}, 4'd1);
    btn_r2 = 1'b0;
    tick(0, 1);
    chk("right_dir_2", dir_2, 4'b0010);
    repeat (3) tick(1, 0);
    game_active = 1'b0;
    tick(0, 0);
    game_active = 1'b1;
    repeat (3) press_l1();
    chk("full_qcnt_1", {1'b0, qcnt_1}, 4'd2);
    chk("full_ovf_1", {3'b0, ovf_1}, 4'd1);
    tick(0, 1);
    chk("step1_dir_1", dir_1, 4'b0010);
    tick(0, 1);
    chk("step2_dir_1", dir_1, 4'b0100);
    tick(0, 1);
    chk("step3_dir_1", dir_1, 4'b0100);
    btn_l1 = 1'b1;
    btn_r1 = 1'b1;
    repeat (3) tick(1, 0);
    repeat (2) tick(0, 0);
    chk("lr_qcnt_1", {1'b0, qcnt_1}, 4'd1);
    btn_l1 = 1'b0;
    btn_r1 = 1'b0;
    repeat (3) tick(1, 0);
    tick(0, 1);
    chk("lr_left_dir_1", dir_1, 4'b1000);
    press_l1();
    chk("pre_drop_qcnt_1", {1'b0, qcnt_1}, 4'd1);
    game_active = 1'b0;
    tick(0, 0);
    chk("drop_qcnt_1", {1'b0, qcnt_1}, 4'd0);
    chk("drop_dir_1", dir_1, 4'b0001);
    chk("drop_ovf_1", {3'b0, ovf_1}, 4'd1);
    btn_l2 = 1'b1;
    repeat (4) tick(1, 0);
    game_active = 1'b1;
    repeat (4) tick(1, 0);
    chk("held_qcnt_2", {1'b0, qcnt_2}, 4'd0);
    btn_l2 = 1'b0;
    repeat (3) tick(1, 0);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(5) == 0) btn_l1 = ~btn_l1;
      if ($urandom_range(5) == 0) btn_r1 = ~btn_r1;
      if ($urandom_range(5) == 0) btn_l2 = ~btn_l2;
      if ($urandom_range(5) == 0) btn_r2 = ~btn_r2;
      if (game_active ? ($urandom_range(299) == 0) : ($urandom_range(9) == 0)) game_active = ~game_active;
      tick(1'($urandom_range(2) == 0), 1'($urandom_range(5) == 0));
    end
    btn_l1 = 1'b0;
    btn_r1 = 1'b0;
    btn_l2 = 1'b0;
    btn_r2 = 1'b0;
    repeat (3) tick(1, 0);
    game_active = 1'b0;
    tick(0, 0);
    game_active = 1'b1;
    btn_l1 = 1'b1;
    repeat (3) tick(1, 0);
    tick(0, 0);
    chk("mid_qcnt_1", {1'b0, qcnt_1}, 4'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_dir_1", dir_1, 4'b0001);
    chk("async_dir_2", dir_2, 4'b0100);
    chk("async_qcnt_1", {1'b0, qcnt_1}, 4'd0);
    chk("async_ovf", {2'b0, ovf_1, ovf_2}, 4'd0);
    tick(0, 0);
    rst = 1'b0;
    repeat (6) tick(1, 0);
    btn_l1 = 1'b0;
    repeat (4) tick(1, 0);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cycle_input_ctrl.md
Name: cycle_input_ctrl

Overview:
- Upstream stage of the Light-Cycles game core. It conditions the four raw turn buttons (two per player) and produces each player's current heading as a one-hot LURD vector that the core reads on every game step.
- Each button is debounced on the display-rate sample tick. Each clean press becomes a turn command in a small per-player queue.
- One queued turn is applied per game step, so presses made between steps are kept, not lost.

Parameters:
- DEB_LEN, 3: consecutive equal samples required to change a debounced level (2..8).
- Q_DEPTH, 2: turn-queue entries per player (1..4).
- INIT_DIR_1, 4'b0001: player 1 heading at reset and while idle (down).
- INIT_DIR_2, 4'b0100: player 2 heading at reset and while idle (up).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- sample_en  in  1  one-cycle debounce sample strobe (segclk-rate).
- step_en  in  1  one-cycle game-step strobe (gclk-rate).
- game_active  in  1  high once the countdown has finished.
- btn_l1  in  1  player 1 turn-left button, raw.
- btn_r1  in  1  player 1 turn-right button, raw.
- btn_l2  in  1  player 2 turn-left button, raw.
- btn_r2  in  1  player 2 turn-right button, raw.
- dir_1  out  4  player 1 heading, one-hot {L,U,R,D}.
- dir_2  out  4  player 2 heading, one-hot {L,U,R,D}.
- qcnt_1  out  3  player 1 pending turn count.
- qcnt_2  out  3  player 2 pending turn count.
- ovf_1  out  1  sticky: a player 1 press was dropped because the queue was full.
- ovf_2  out  1  sticky: a player 2 press was dropped because the queue was full.

Behaviour:
- Reset (asynchronous, any time, including mid-queue):
  - dir_1=INIT_DIR_1, dir_2=INIT_DIR_2.
  - Queues empty, qcnt_*=0, ovf_*=0.
  - Debounce histories and debounced levels = 0.
- Debounce, per button:
  - The history shift register advances only on sample_en.
  - Debounced level goes to 1 when the last DEB_LEN samples are all 1, and to 0 when they are all 0; otherwise it holds.
  - A press event is a 0->1 transition of the debounced level. It is a single-cycle pulse in the cycle after the qualifying sample_en.
  - A release produces no event. A button held continuously produces exactly one press.
- Press encoding and arbitration:
  - Left press = command 0, right press = command 1.
  - If L and R press events for the same player occur in the same cycle, only L is enqueued.
  - The two players are fully independent.
- Queue, per player: FIFO of depth Q_DEPTH, 1-bit entries.
  - Push on a press event while game_active=1.
  - Pop on step_en while game_active=1 and the queue is non-empty.
  - Simultaneous push and pop: both happen and qcnt is unchanged. This holds even when the queue is full (push accepted).
  - Push when full with no pop: the press is dropped and ovf is set. ovf clears only on rst.
  - Pop when empty: no change.
- Heading update:
  - The popped command is applied as a registered update, visible the cycle after step_en.
  - Left: dir <= {dir[2:0],dir[3]}. Right: dir <= {dir[0],dir[3:1]}.
  - Reference points: down 0001 -L-> 0010 right; left 1000 -L-> 0001 down; down 0001 -R-> 1000 left.
  - The core samples dir on the same step_en strobe, so a turn popped at step k steers the move at step k+1.
  - dir stays one-hot at all times. U-turns are impossible because one command = one 90-degree rotation.
- game_active=0:
  - Queues are flushed (qcnt=0) and press events are discarded.
  - dir is forced to its INIT value. The debouncers keep running.
  - A button already held when game_active rises produces no press.
- game_active falling mid-operation flushes on the next cycle. ovf is retained.
- sample_en and step_en in the same cycle: a press event generated there is pushed one cycle later than the pop.
- Implementation: no combinational path from btn_* to any output.

Test Plan:
- Reset, then 10 sample_en with all buttons low -> dir_1=0001, dir_2=0100, qcnt=0, ovf=0.
- game_active=1; hold btn_l1 high for 3 samples; then step_en -> qcnt_1 reaches 1 one cycle after the 3rd sample; dir_1=0010 the cycle after step_en; qcnt_1=0.
- Bounce btn_r2 1,0,1,0 over four samples -> no press, qcnt_2=0; then hold 3 samples -> one press; after step_en, dir_2=0010.
- Three clean player 1 presses with no step (Q_DEPTH=2) -> qcnt_1=2, ovf_1=1. Two step_en -> dir_1 goes 0001->0010->0100 (two left turns); a 3rd step leaves dir_1 at 0100.
- btn_l1 and btn_r1 rise on the same sample -> one left command only; qcnt_1=1.
- Queue one turn, then drop game_active -> qcnt_1=0 and dir_1=0001 next cycle. Assert rst mid-queue -> all outputs return to reset values asynchronously.
